mult_pipe: RTL and testbench

MULT_PIPE -- requirements
Module: mult_pipe

---
 rtl/sys_defs.sv | 33 +++
 rtl/mult_pipe_stage.sv | 84 ++++++++
 rtl/mult_pipe.sv | 119 +++++++++++
 tb/tb_mult_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared system definitions: multiplier operation encoding and the default
// pipeline depth used by the execute stage.
`ifndef SYS_MULT_STAGES
`define SYS_MULT_STAGES 4
`endif

package sys_defs;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_func_t;

  localparam int MULT_DEFAULT_STAGES = `SYS_MULT_STAGES;

  // rs1 is treated as signed for the two signed-high variants
  function automatic logic rs1_is_signed(input mult_func_t f);
    return (f == MULH) || (f == MULHSU);
  endfunction

  // rs2 is treated as signed only when both operands are signed
  function automatic logic rs2_is_signed(input mult_func_t f);
    return (f == MULH);
  endfunction

  // every variant except MUL returns the upper half of the product
  function automatic logic wants_high_half(input mult_func_t f);
    return (f != MUL);
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One multiplier pipeline stage: adds CHUNK multiplier bits times the
// shifted multiplicand into the running sum, then shifts both operands on.
module mult_pipe_stage
  import sys_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 16,
  parameter int TAG_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              advance,
  input  logic              in_valid,
  input  mult_func_t        in_func,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [2*XLEN-1:0] in_mcand,
  input  logic [2*XLEN-1:0] in_mplier,
  input  logic [2*XLEN-1:0] in_sum,
  output logic              out_valid,
  output mult_func_t        out_func,
  output logic [TAG_W-1:0]  out_tag,
  output logic [2*XLEN-1:0] out_mcand,
  output logic [2*XLEN-1:0] out_mplier,
  output logic [2*XLEN-1:0] out_sum
);

  localparam int PW = 2 * XLEN;

  logic             valid_q,  valid_d;
  mult_func_t       func_q,   func_d;
  logic [TAG_W-1:0] tag_q,    tag_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [PW-1:0]    mplier_q, mplier_d;
  logic [PW-1:0]    sum_q,    sum_d;
  logic [PW-1:0]    chunk_ext;
  logic [PW-1:0]    pp;

  // Next-state: hold everything on stall, otherwise take the partial-product step
  always_comb begin
    chunk_ext              = '0;
    chunk_ext[CHUNK-1:0]   = in_mplier[CHUNK-1:0];
    pp                     = in_mcand * chunk_ext;
    valid_d                = valid_q;
    func_d                 = func_q;
    tag_d                  = tag_q;
    mcand_d                = mcand_q;
    mplier_d               = mplier_q;
    sum_d                  = sum_q;
    if (advance) begin
      valid_d  = in_valid;
      func_d   = in_func;
      tag_d    = in_tag;
      mcand_d  = in_mcand << CHUNK;
      mplier_d = in_mplier >> CHUNK;
      sum_d    = in_sum + pp;
    end
    // flush kills the op regardless of stall state
    if (flush) valid_d = 1'b0;
  end

  // Control state: valid bit, cleared asynchronously by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // Data state: meaningless while valid is low, so it carries no reset
  always_ff @(posedge clock) begin
    func_q   <= func_d;
    tag_q    <= tag_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    sum_q    <= sum_d;
  end

  assign out_valid  = valid_q;
  assign out_func   = func_q;
  assign out_tag    = tag_q;
  assign out_mcand  = mcand_q;
  assign out_mplier = mplier_q;
  assign out_sum    = sum_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined integer multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready
// handshakes on both sides, tag passthrough and a pipeline-wide flush.
module mult_pipe
  import sys_defs::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_STAGE = `SYS_MULT_STAGES,
  parameter int TAG_W     = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       func,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW    = 2 * XLEN;
  localparam int CHUNK = PW / NUM_STAGE;
  localparam int LAST  = NUM_STAGE - 1;

  if ((PW % NUM_STAGE) != 0) begin : g_bad_num_stage
    $error("mult_pipe: NUM_STAGE must divide 2*XLEN");
  end

  // si_* feed stage k, so_* come out of stage k
  logic             si_valid  [NUM_STAGE];
  mult_func_t       si_func   [NUM_STAGE];
  logic [TAG_W-1:0] si_tag    [NUM_STAGE];
  logic [PW-1:0]    si_mcand  [NUM_STAGE];
  logic [PW-1:0]    si_mplier [NUM_STAGE];
  logic [PW-1:0]    si_sum    [NUM_STAGE];
  logic             so_valid  [NUM_STAGE];
  mult_func_t       so_func   [NUM_STAGE];
  logic [TAG_W-1:0] so_tag    [NUM_STAGE];
  logic [PW-1:0]    so_mcand  [NUM_STAGE];
  logic [PW-1:0]    so_mplier [NUM_STAGE];
  logic [PW-1:0]    so_sum    [NUM_STAGE];
  logic [NUM_STAGE:0] adv;
  mult_func_t       func_in;
  logic             unused_tail;

  // Operand extension into stage 0 and stage-to-stage forwarding
  always_comb begin
    func_in      = mult_func_t'(func);
    si_valid[0]  = in_valid;
    si_func[0]   = func_in;
    si_tag[0]    = in_tag;
    si_mcand[0]  = {{XLEN{rs1_is_signed(func_in) & rs1[XLEN-1]}}, rs1};
    si_mplier[0] = {{XLEN{rs2_is_signed(func_in) & rs2[XLEN-1]}}, rs2};
    si_sum[0]    = '0;
    for (int k = 1; k < NUM_STAGE; k++) begin
      si_valid[k]  = so_valid[k-1];
      si_func[k]   = so_func[k-1];
      si_tag[k]    = so_tag[k-1];
      si_mcand[k]  = so_mcand[k-1];
      si_mplier[k] = so_mplier[k-1];
      si_sum[k]    = so_sum[k-1];
    end
  end

  // Backpressure: a stage moves if it is empty or the one after it moves
  always_comb begin
    adv[NUM_STAGE] = out_ready;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      adv[k] = !so_valid[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    mult_pipe_stage #(
      .XLEN  (XLEN),
      .CHUNK (CHUNK),
      .TAG_W (TAG_W)
    ) u_stage (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .advance    (adv[k]),
      .in_valid   (si_valid[k]),
      .in_func    (si_func[k]),
      .in_tag     (si_tag[k]),
      .in_mcand   (si_mcand[k]),
      .in_mplier  (si_mplier[k]),
      .in_sum     (si_sum[k]),
      .out_valid  (so_valid[k]),
      .out_func   (so_func[k]),
      .out_tag    (so_tag[k]),
      .out_mcand  (so_mcand[k]),
      .out_mplier (so_mplier[k]),
      .out_sum    (so_sum[k])
    );
  end

  // The last stage's shifted operands have nowhere left to go
  assign unused_tail = ^{so_mcand[LAST], so_mplier[LAST]};

  // Output select; result and tag read as zero whenever nothing is valid
  always_comb begin
    out_valid = so_valid[LAST];
    result    = '0;
    out_tag   = '0;
    if (out_valid) begin
      out_tag = so_tag[LAST];
      result  = wants_high_half(so_func[LAST]) ? so_sum[LAST][PW-1:XLEN]
                                               : so_sum[LAST][XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed scenarios with literal
// expectations plus randomized traffic against a queue-based product model.
module tb_mult_pipe;

  localparam int XLEN = 32;
  localparam int NS   = 4;
  localparam int TW   = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      func;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [TW-1:0]   in_tag;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [TW-1:0]   out_tag;

  mult_pipe #(.XLEN(XLEN), .NUM_STAGE(NS), .TAG_W(TW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .rs1       (rs1),
    .rs2       (rs2),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [TW-1:0]   tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_out = 0;

  // Reference product from plain 64-bit arithmetic on the extended operands
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] f,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      2'd0:    p = 64'(ua * ub);
      2'd1:    p = 64'(sa * sb);
      2'd2:    p = 64'(sa * ub);
      default: p = 64'(ua * ub);
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model and compare process: every cycle, away from the active edge
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result",    64'(result),    64'd0);
      chk("rst_out_tag",   64'(out_tag),   64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'((q.size() < NS) || out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("result",  64'(result),  64'(q[0].res));
          chk("out_tag", 64'(out_tag), 64'(q[0].tag));
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{ref_mul(func, rs1, rs2), in_tag});
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    func     = 2'd0;
    rs1      = '0;
    rs2      = '0;
    in_tag   = '0;
  endtask

  // Single op into an empty pipe with out_ready high; checks latency and value
  task automatic issue_and_wait(input string nm, input logic [1:0] f,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [TW-1:0] t, input logic [XLEN-1:0] exp_res);
    int lat;
    @(posedge clock); #1;
    out_ready = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1; func = f; rs1 = a; rs2 = b; in_tag = t;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(NS));
    chk({nm, "_result"},  64'(result), 64'(exp_res));
    chk({nm, "_tag"},     64'(out_tag), 64'(t));
  endtask

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc;
    int base;
    int waited;
    logic took;

    reset = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;

    // model self-pins against hand-computed values
    chk("ref_mul_7x6",   64'(ref_mul(2'd0, 32'd7, 32'd6)), 64'd42);
    chk("ref_mulh_m1",   64'(ref_mul(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'h0);
    chk("ref_mulhu_m1",  64'(ref_mul(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);
    chk("ref_mulhsu_m1", 64'(ref_mul(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFF);

    // basic latency and tag
    issue_and_wait("mul_7x6", 2'd0, 32'd7, 32'd6, 6'd5, 32'd42);

    // all-ones corner across every function
    issue_and_wait("mulh_m1",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 32'h0000_0000);
    issue_and_wait("mulhu_m1",  2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 32'hFFFF_FFFE);
    issue_and_wait("mulhsu_m1", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 32'hFFFF_FFFF);
    issue_and_wait("mul_m1",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 32'h0000_0001);

    // backpressure: six back-to-back MULs with the consumer stalled
    @(posedge clock); #1;
    out_ready = 1'b0;
    base = n_out;
    acc = 0;
    in_valid = 1'b1; func = 2'd0; rs1 = $urandom; rs2 = $urandom; in_tag = 6'd10;
    repeat (10) begin
      @(negedge clock);
      took = in_valid && in_ready;
      @(posedge clock); #1;
      if (took) begin
        acc++;
        if (acc < 6) begin
          rs1 = $urandom; rs2 = $urandom; in_tag = 6'(10 + acc);
        end else in_valid = 1'b0;
      end
    end
    chk("bp_accepted_while_stalled", 64'(acc), 64'd4);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    waited = 0;
    while (acc < 6 && waited < 40) begin
      @(negedge clock);
      took = in_valid && in_ready;
      @(posedge clock); #1;
      waited++;
      if (took) begin
        acc++;
        if (acc < 6) begin
          rs1 = $urandom; rs2 = $urandom; in_tag = 6'(10 + acc);
        end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (NS + 2) @(posedge clock);
    #1;
    chk("bp_all_six_delivered", 64'(n_out - base), 64'd6);

    // flush kills everything in flight, including the op offered with it
    @(posedge clock); #1;
    base = n_out;
    in_valid = 1'b1; func = 2'd0; rs1 = 32'd11; rs2 = 32'd12; in_tag = 6'd20;
    @(posedge clock); #1;
    rs1 = 32'd13; in_tag = 6'd21;
    @(posedge clock); #1;
    rs1 = 32'd14; in_tag = 6'd22; flush = 1'b1;
    @(posedge clock); #1;
    idle_inputs();
    repeat (6) begin
      chk("flush_no_output", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
    end
    chk("flush_nothing_delivered", 64'(n_out - base), 64'd0);
    issue_and_wait("post_flush_mulh", 2'd1, 32'h8000_0000, 32'h8000_0000, 6'd30, 32'h4000_0000);

    // asynchronous reset with a result waiting at the output
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; func = 2'd0; rs1 = 32'd5; rs2 = 32'd5; in_tag = 6'd40;
    @(posedge clock); #1;
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'd0);
    chk("async_reset_result",    64'(result),    64'd0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    issue_and_wait("post_reset_mul", 2'd0, 32'd3, 32'd3, 6'd41, 32'd9);

    // randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      in_valid  = ($urandom_range(0, 99) < 70);
      func      = 2'($urandom_range(0, 3));
      rs1       = pick_operand();
      rs2       = pick_operand();
      in_tag    = 6'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
    end

    // drain
    @(posedge clock); #1;
    idle_inputs();
    out_ready = 1'b1;
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
